// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths and FSM state encoding for the register write arbiter.
package reg_write_arbiter_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned DEF_ADDR_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/reg_write_arbiter_reg_bank.sv
// Register bank: NUM_REGS x DATA_W registers, per-register write enable,
// shared write data, combinational read mux (zero for out-of-range reads).
module reg_bank
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REGS = 6,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REGS-1:0] we,
    input  logic [DATA_W-1:0]   wd,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (we[i]) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    // Decoded read mux; addresses with no matching register read as zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = regs[i];
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one write requester at a time into a shared
// register bank; one write every two cycles, registered grant/strobe outputs.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_REGS = 6,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          REQ,
    input  logic [NUM_REQ*ADDR_W-1:0]   ADDR,
    input  logic [NUM_REQ*DATA_W-1:0]   WDATA,
    output logic [NUM_REQ-1:0]          GNT,
    output logic [NUM_REGS-1:0]         WE,
    output logic [DATA_W-1:0]           WD,
    output logic                        ERR,
    output logic                        BUSY,
    input  logic [ADDR_W-1:0]           RD_ADDR,
    output logic [DATA_W-1:0]           RD_DATA
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    idx_q, idx_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REGS-1:0] we_q, we_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic                found;
    logic [PTR_W-1:0]    win;
    logic [PTR_W-1:0]    cand;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   data_sel;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            we_q    <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next state plus the values the outputs take during the following cycle.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        gnt_d    = '0;
        we_d     = '0;
        wd_d     = '0;
        err_d    = 1'b0;
        busy_d   = 1'b0;
        found    = 1'b0;
        win      = '0;
        cand     = '0;
        addr_sel = '0;
        data_sel = '0;

        case (state_q)
            ST_IDLE: begin
                // First requester at or above the pointer, wrapping around.
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
                    if (!found && REQ[cand]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    if (win == PTR_W'(k)) begin
                        addr_sel = ADDR[k*ADDR_W +: ADDR_W];
                        data_sel = WDATA[k*DATA_W +: DATA_W];
                    end
                end
                if (found) begin
                    state_d = ST_WRITE;
                    idx_d   = win;
                    gnt_d   = NUM_REQ'(1) << win;
                    for (int unsigned r = 0; r < NUM_REGS; r++) begin
                        we_d[r] = (addr_sel == ADDR_W'(r));
                    end
                    wd_d    = data_sel;
                    err_d   = (32'(addr_sel) >= NUM_REGS);
                    busy_d  = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (32'(idx_q) == NUM_REQ - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = idx_q + PTR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign GNT  = gnt_q;
    assign WE   = we_q;
    assign WD   = wd_q;
    assign ERR  = err_q;
    assign BUSY = busy_q;

    reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_bank (
        .clk     (CLK),
        .rst     (RST),
        .we      (we_q),
        .wd      (wd_q),
        .rd_addr (RD_ADDR),
        .rd_data (RD_DATA)
    );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters.
module tb_reg_write_arbiter;

    localparam int NR = 4;
    localparam int NG = 6;
    localparam int AW = 3;

    logic             CLK;
    logic             RST;
    logic [NR-1:0]    REQ;
    logic [NR*AW-1:0] ADDR;
    logic [NR*8-1:0]  WDATA;
    logic [NR-1:0]    GNT;
    logic [NG-1:0]    WE;
    logic [7:0]       WD;
    logic             ERR;
    logic             BUSY;
    logic [AW-1:0]    RD_ADDR;
    logic [7:0]       RD_DATA;

    logic [AW-1:0]    a_addr [NR];
    logic [7:0]       a_data [NR];

    int n_vec;
    int n_err;

    // Transaction model state
    bit        m_busy;
    int        m_ptr;
    int        m_win;
    int        m_addr;
    logic [7:0] m_data;
    logic [7:0] m_bank [8];

    logic [3:0] t3_exp [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    reg_write_arbiter #(
        .NUM_REQ  (NR),
        .NUM_REGS (NG),
        .ADDR_W   (AW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .ADDR    (ADDR),
        .WDATA   (WDATA),
        .GNT     (GNT),
        .WE      (WE),
        .WD      (WD),
        .ERR     (ERR),
        .BUSY    (BUSY),
        .RD_ADDR (RD_ADDR),
        .RD_DATA (RD_DATA)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            ADDR[i*AW +: AW] = a_addr[i];
            WDATA[i*8 +: 8]  = a_data[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = 0;
        m_win  = 0;
        m_addr = 0;
        m_data = 8'h00;
        for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
    endtask

    // One clock edge of the model: finish a pending write or pick a winner.
    task automatic model_edge();
        bit got;
        if (RST) begin
            model_reset();
        end else if (m_busy) begin
            if (m_addr < NG) m_bank[m_addr] = m_data;
            m_ptr  = (m_win + 1) % NR;
            m_busy = 1'b0;
        end else if (REQ != '0) begin
            got = 1'b0;
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_ptr + k) % NR;
                if (!got && REQ[c]) begin
                    got   = 1'b1;
                    m_win = c;
                end
            end
            m_addr = int'(a_addr[m_win]);
            m_data = a_data[m_win];
            m_busy = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic [NR-1:0] eg;
        logic [NG-1:0] ew;
        logic [7:0]    er;
        eg = '0;
        ew = '0;
        if (m_busy) eg[m_win] = 1'b1;
        if (m_busy && m_addr < NG) ew[m_addr] = 1'b1;
        er = (int'(RD_ADDR) < NG) ? m_bank[RD_ADDR] : 8'h00;
        chk("gnt",     32'(GNT),     32'(eg));
        chk("we",      32'(WE),      32'(ew));
        chk("wd",      32'(WD),      m_busy ? 32'(m_data) : 32'h0);
        chk("err",     32'(ERR),     32'(m_busy && m_addr >= NG));
        chk("busy",    32'(BUSY),    32'(m_busy));
        chk("rd_data", 32'(RD_DATA), 32'(er));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    // Called at edge+1: assert RST mid-cycle and check outputs drop at once.
    task automatic rst_mid();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        compare_all();
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] d);
        REQ[i]    = 1'b1;
        a_addr[i] = a;
        a_data[i] = d;
    endtask

    task automatic agents();
        for (int i = 0; i < NR; i++) begin
            if (REQ[i] && m_busy && m_win == i) begin
                REQ[i] = 1'b0;
            end else if (!REQ[i] && $urandom_range(3) == 0) begin
                set_req(i, AW'($urandom_range(7)), 8'($urandom));
            end
        end
        RD_ADDR = AW'($urandom_range(7));
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        RST     = 1'b1;
        REQ     = '0;
        RD_ADDR = '0;
        for (int i = 0; i < NR; i++) begin
            a_addr[i] = '0;
            a_data[i] = '0;
        end
        model_reset();
        tick();
        tick();
        RST = 1'b0;
        chk("reset_gnt",  32'(GNT),  32'h0);
        chk("reset_busy", 32'(BUSY), 32'h0);

        // Warm-up random traffic so the mid-run reset clears real contents
        for (int c = 0; c < 150; c++) begin
            agents();
            tick();
        end

        // Reset mid-run, bank reads zero everywhere
        rst_mid();
        REQ = '0;
        for (int a = 0; a < 8; a++) begin
            RD_ADDR = AW'(a);
            #1;
            chk("rst_rd", 32'(RD_DATA), 32'h0);
        end
        chk("rst_gnt", 32'(GNT), 32'h0);
        chk("rst_we",  32'(WE),  32'h0);
        tick();
        RST = 1'b0;

        // Single request from requester 0 after reset
        set_req(0, 3'd0, 8'h11);
        tick();
        chk("t1_gnt", 32'(GNT), 32'h1);
        chk("t1_we",  32'(WE),  32'h01);
        REQ = '0;
        tick();

        // Single write to register 3
        set_req(2, 3'd3, 8'hA5);
        tick();
        chk("t2_gnt", 32'(GNT), 32'b0100);
        chk("t2_we",  32'(WE),  32'b001000);
        chk("t2_wd",  32'(WD),  32'hA5);
        REQ = '0;
        RD_ADDR = 3'd3;
        tick();
        chk("t2_rd3", 32'(RD_DATA), 32'hA5);
        RD_ADDR = 3'd0;
        tick();
        chk("t2_rd0", 32'(RD_DATA), 32'h11);

        // Saturated requests after a fresh reset: strict rotation
        rst_mid();
        REQ = '0;
        tick();
        RST = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, AW'(i), 8'(8'h10 + i));
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t3_gnt", 32'(GNT), 32'(t3_exp[c]));
        end
        REQ = '0;

        // Pointer wrap: grant 1, then {3,0} resolves to 3 then 0
        set_req(1, 3'd4, 8'h44);
        tick();
        chk("t4_gnt1", 32'(GNT), 32'b0010);
        REQ = '0;
        tick();
        set_req(0, 3'd5, 8'h50);
        set_req(3, 3'd1, 8'h31);
        tick();
        chk("t4_gnt3", 32'(GNT), 32'b1000);
        tick();
        REQ[3] = 1'b0;
        tick();
        chk("t4_gnt0", 32'(GNT), 32'b0001);
        REQ = '0;
        tick();

        // Invalid address: error pulse, no bank write
        set_req(1, 3'd7, 8'hFF);
        tick();
        chk("t5_gnt", 32'(GNT), 32'b0010);
        chk("t5_err", 32'(ERR), 32'h1);
        chk("t5_we",  32'(WE),  32'h0);
        REQ = '0;
        for (int a = 0; a < 8; a++) begin
            RD_ADDR = AW'(a);
            tick();
        end

        // Reset during WRITE: strobes drop at once, no write, pointer to 0
        RD_ADDR = 3'd2;
        set_req(0, 3'd2, 8'h3C);
        tick();
        chk("t6_gnt", 32'(GNT), 32'b0001);
        chk("t6_we",  32'(WE),  32'b000100);
        rst_mid();
        chk("t6_gnt0", 32'(GNT), 32'h0);
        chk("t6_we0",  32'(WE),  32'h0);
        chk("t6_rd2",  32'(RD_DATA), 32'h0);
        REQ = '0;
        tick();
        RST = 1'b0;
        chk("t6_rd2b", 32'(RD_DATA), 32'h0);
        for (int i = 0; i < NR; i++) set_req(i, AW'(i), 8'(8'h20 + i));
        tick();
        chk("t6_ptr0", 32'(GNT), 32'b0001);
        REQ = '0;
        tick();

        // Randomized requesters with occasional asynchronous reset
        for (int c = 0; c < 1500; c++) begin
            agents();
            tick();
            if ($urandom_range(99) == 0) begin
                rst_mid();
                tick();
                RST = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Round-robin arbiter that shares a small bank of 8-bit registers among NUM_REQ write requesters.
- Each requester presents a request, a target address and data.
- The block grants one requester at a time, drives that register's write enable and data for one cycle, and acknowledges with a grant pulse.
- Sits between execution/control units and the register bank it owns.
- A combinational read port exposes bank contents.

Parameters:
NUM_REQ, 4, number of write requesters (2..8)
NUM_REGS, 6, number of 8-bit registers in the bank (1..2**ADDR_W)
ADDR_W, 3, register address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
REQ  in  NUM_REQ  per-requester write request, level
ADDR  in  NUM_REQ*ADDR_W  packed target addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
WDATA  in  NUM_REQ*8  packed write data; requester i uses bits [i*8 +: 8]
GNT  out  NUM_REQ  one-hot grant/ack pulse, 1 cycle
WE  out  NUM_REGS  one-hot register write enable (to bank, also exported)
WD  out  8  data being written
ERR  out  1  pulse: granted write targeted an invalid address (>= NUM_REGS)
BUSY  out  1  high while in WRITE state
RD_ADDR  in  ADDR_W  read address
RD_DATA  out  8  bank contents at RD_ADDR, combinational; 8'h00 if RD_ADDR >= NUM_REGS

Behaviour:
- Reset (async, immediate): state=IDLE, rr pointer=0, all bank registers=8'h00, latched idx/addr/data=0. GNT=0, WE=0, WD=0, ERR=0, BUSY=0.
- States: IDLE, WRITE.
- IDLE:
  - If any REQ bit is high at the rising edge, choose the winner as the first set REQ bit searching from the pointer upward, wrapping at NUM_REQ-1 -> 0.
  - Latch the winner index, its ADDR slice and its WDATA slice; go to WRITE.
  - Otherwise stay in IDLE. All outputs 0 in IDLE.
- WRITE (exactly 1 cycle):
  - GNT[winner]=1 and BUSY=1.
  - Valid address: WE[addr]=1, WD=latched data, ERR=0.
  - Invalid address: WE=0, WD=latched data, ERR=1.
  - On the edge, the bank register is updated (valid address only), pointer becomes (winner+1) mod NUM_REQ, and state returns to IDLE.
- Latency: REQ sampled high at edge k -> GNT/WE high during cycle k+1 -> data visible on RD_DATA after edge k+2.
- Throughput: one write every 2 cycles.
- Handshake:
  - Requester holds REQ/ADDR/WDATA stable until it sees GNT.
  - Requester deasserts REQ in the cycle after GNT.
  - If REQ is still high in IDLE it is treated as a new request.
  - REQ/ADDR/WDATA changes during WRITE have no effect; data is already latched.
- Fairness: a continuously requesting set is served in strictly rotating order; a requester waits at most NUM_REQ grants.
- Read/write same register in the WRITE cycle: RD_DATA shows the old value until the edge, then the new value.
- Non-granted bank registers hold their value.
- RST mid-WRITE: GNT/WE/ERR drop immediately, no write occurs, bank cleared, pointer=0.
- Width rules: the ADDR compare against NUM_REGS is unsigned; no arithmetic on data.

Decomposition:
- Shared package/include: state encodings (ST_IDLE, ST_WRITE), default widths (DATA_W=8, ADDR_W).
- One sub-module: reg_bank, NUM_REGS x 8-bit registers with per-register write enable, shared data in, async active-high reset to 0, combinational read mux.
- Arbiter FSM, round-robin pointer and priority search stay in reg_write_arbiter.

Test Plan:
1. Reset then idle: assert RST mid-run -> all RD_DATA reads 8'h00, GNT=0, WE=0, BUSY=0; next single request from requester 0 wins.
2. Single write: REQ=4'b0100, ADDR[2]=3, WDATA[2]=8'hA5 -> next cycle GNT=4'b0100, WE=6'b001000, WD=8'hA5; after the following edge RD_ADDR=3 gives 8'hA5, all other registers unchanged.
3. Saturated requests: REQ=4'b1111 held, each requester drops/re-raises after its GNT, addresses 0..3 -> GNT order 0,1,2,3,0, one grant every 2 cycles.
4. Pointer wrap: after a grant to requester 1 (pointer=2), REQ=4'b1001 -> grant 3 first, then 0.
5. Invalid address: ADDR[1]=7, WDATA=8'hFF -> GNT=4'b0010, ERR=1, WE=0; bank contents unchanged.
6. Reset during WRITE: assert RST while GNT[0]=1 with ADDR=2/8'h3C -> GNT and WE fall the same cycle; RD_ADDR=2 reads 8'h00; pointer restarts at 0.
